// File: rtl/hd63701_timer_pkg.sv
// Shared definitions for the HD63701 16-bit programmable timer: register map, TCSR bit layout
// and the FRC value forced by an FRCH write.
package hd63701_timer_pkg;
  localparam logic [2:0] TMR_TCSR = 3'd0;
  localparam logic [2:0] TMR_FRCH = 3'd1;
  localparam logic [2:0] TMR_FRCL = 3'd2;
  localparam logic [2:0] TMR_OCRH = 3'd3;
  localparam logic [2:0] TMR_OCRL = 3'd4;
  localparam logic [2:0] TMR_ICRH = 3'd5;
  localparam logic [2:0] TMR_ICRL = 3'd6;

  localparam int B_ICF  = 7;
  localparam int B_OCF  = 6;
  localparam int B_TOF  = 5;
  localparam int B_EICI = 4;
  localparam int B_EOCI = 3;
  localparam int B_ETOI = 2;
  localparam int B_IEDG = 1;
  localparam int B_OLVL = 0;

  localparam logic [15:0] FRC_WR_PRESET_DEF = 16'hFFF8;
endpackage

// File: rtl/hd63701_timer_if.sv
// Register-window bus between the execution unit (master) and the timer (slave).
interface hd63701_timer_if;
  logic       sel;
  logic [2:0] ra;
  logic       rd;
  logic       wr;
  logic [7:0] di;
  logic [7:0] dout;

  modport master (output sel, ra, rd, wr, di, input dout);
  modport slave  (input sel, ra, rd, wr, di, output dout);
endinterface

// File: rtl/hd63701_timer_edge.sv
// P20 synchroniser and E-cycle edge detector; cap_pulse is high for the single CE cycle in
// which the selected edge is seen against the previous CE sample.
module hd63701_timer_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLKp,
  input  logic RST,
  input  logic CE,
  input  logic p20,
  input  logic iedg,
  output logic cap_pulse
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge CLKp) begin
    if (RST) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], p20};
      if (CE) prev <= s;
    end
  end

  assign cap_pulse = CE & (iedg ? (s & ~prev) : (~s & prev));
endmodule

// File: rtl/hd63701_timer.sv
// HD63701 on-chip timer: free-running counter, output compare, input capture and the
// TCSR flag/arm logic behind the two-step clear sequence.
module hd63701_timer
  import hd63701_timer_pkg::*;
#(
  parameter logic [15:0] FRC_WR_PRESET = FRC_WR_PRESET_DEF,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic                  CLKp,
  input  logic                  RST,
  input  logic                  CE,
  hd63701_timer_if.slave        bus,
  input  logic                  p20,
  output logic                  p21,
  output logic                  irq_ici,
  output logic                  irq_oci,
  output logic                  irq_toi
);
  logic [15:0] frc, ocr, icr;
  logic [7:0]  tcsr, temp, lsb_buf, rdata;
  logic [7:5]  arm, set, clr;
  logic        cmp_inh, cap_pulse, acc;
  logic        rd_tcsr, rd_frch, rd_icrh;
  logic        wr_tcsr, wr_frch, wr_frcl, wr_ocrh, wr_ocrl, frc_wr, ocr_wr;

  hd63701_timer_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
    .CLKp      (CLKp),
    .RST       (RST),
    .CE        (CE),
    .p20       (p20),
    .iedg      (tcsr[B_IEDG]),
    .cap_pulse (cap_pulse)
  );

  assign acc     = bus.sel & CE;
  assign rd_tcsr = acc & bus.rd & (bus.ra == TMR_TCSR);
  assign rd_frch = acc & bus.rd & (bus.ra == TMR_FRCH);
  assign rd_icrh = acc & bus.rd & (bus.ra == TMR_ICRH);
  assign wr_tcsr = acc & bus.wr & (bus.ra == TMR_TCSR);
  assign wr_frch = acc & bus.wr & (bus.ra == TMR_FRCH);
  assign wr_frcl = acc & bus.wr & (bus.ra == TMR_FRCL);
  assign wr_ocrh = acc & bus.wr & (bus.ra == TMR_OCRH);
  assign wr_ocrl = acc & bus.wr & (bus.ra == TMR_OCRL);
  assign frc_wr  = wr_frch | wr_frcl;
  assign ocr_wr  = wr_ocrh | wr_ocrl;

  // Clears need a prior TCSR read; a same-cycle set is applied after the clear so it wins.
  always_comb begin
    set        = '0;
    clr        = '0;
    set[B_ICF] = cap_pulse;
    set[B_OCF] = CE & ~cmp_inh & (frc == ocr);
    set[B_TOF] = CE & ~frc_wr & (&frc);
    clr[B_ICF] = rd_icrh & arm[B_ICF];
    clr[B_OCF] = ocr_wr  & arm[B_OCF];
    clr[B_TOF] = rd_frch & arm[B_TOF];
  end

  always_ff @(posedge CLKp) begin
    if (RST) begin
      frc     <= 16'h0000;
      ocr     <= 16'hFFFF;
      icr     <= 16'h0000;
      tcsr    <= 8'h00;
      temp    <= 8'h00;
      lsb_buf <= 8'h00;
      arm     <= '0;
      cmp_inh <= 1'b0;
      p21     <= 1'b0;
    end else begin
      tcsr[7:5] <= (tcsr[7:5] & ~clr) | set;
      arm       <= (arm | ({3{rd_tcsr}} & tcsr[7:5])) & ~clr;
      if (CE) begin
        if (wr_frch) begin
          temp <= bus.di;
          frc  <= FRC_WR_PRESET;
        end else if (wr_frcl) begin
          frc  <= {temp, bus.di};
        end else begin
          frc  <= frc + 16'd1;
        end
        cmp_inh <= ocr_wr;
      end
      if (wr_tcsr)    tcsr[4:0]  <= bus.di[4:0];
      if (wr_ocrh)    ocr[15:8]  <= bus.di;
      if (wr_ocrl)    ocr[7:0]   <= bus.di;
      if (rd_frch)    lsb_buf    <= frc[7:0];
      if (set[B_OCF]) p21        <= tcsr[B_OLVL];
      if (cap_pulse)  icr        <= frc;
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (bus.sel) begin
      case (bus.ra)
        TMR_TCSR: rdata = tcsr;
        TMR_FRCH: rdata = frc[15:8];
        TMR_FRCL: rdata = lsb_buf;
        TMR_OCRH: rdata = ocr[15:8];
        TMR_OCRL: rdata = ocr[7:0];
        TMR_ICRH: rdata = icr[15:8];
        TMR_ICRL: rdata = icr[7:0];
        default:  rdata = 8'h00;
      endcase
    end
  end

  assign bus.dout = rdata;
  assign irq_ici  = tcsr[B_ICF] & tcsr[B_EICI];
  assign irq_oci  = tcsr[B_OCF] & tcsr[B_EOCI];
  assign irq_toi  = tcsr[B_TOF] & tcsr[B_ETOI];
endmodule

// File: tb/tb_hd63701_timer.sv
// Bench for hd63701_timer: directed vector table, hand-written corner sequences and a
// randomized run against an event-level reference model.
module tb_hd63701_timer;
  import hd63701_timer_pkg::*;

  logic CLKp = 1'b0;
  logic RST, CE, p20, p21, irq_ici, irq_oci, irq_toi;
  hd63701_timer_if bus();

  hd63701_timer dut (
    .CLKp(CLKp), .RST(RST), .CE(CE), .bus(bus), .p20(p20),
    .p21(p21), .irq_ici(irq_ici), .irq_oci(irq_oci), .irq_toi(irq_toi)
  );

  always #5 CLKp = ~CLKp;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] m_frc, m_ocr, m_icr;
  logic [7:0]  m_temp, m_lsb;
  logic [4:0]  m_ctl;
  bit          m_icf, m_ocf, m_tof, a_icf, a_ocf, a_tof, m_inh, m_p21, m_prev;
  bit          sq[$];

  typedef struct {
    bit ce, sel, rd, wr;
    logic [2:0] ra;
    logic [7:0] di;
    logic [7:0] dout;
    logic [2:0] irq;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function logic [7:0] m_read(input logic s, input logic [2:0] a);
    if (!s) return 8'h00;
    case (a)
      3'd0: return {m_icf, m_ocf, m_tof, m_ctl};
      3'd1: return m_frc[15:8];
      3'd2: return m_lsb;
      3'd3: return m_ocr[15:8];
      3'd4: return m_ocr[7:0];
      3'd5: return m_icr[15:8];
      3'd6: return m_icr[7:0];
      default: return 8'h00;
    endcase
  endfunction

  function logic [2:0] m_irq();
    return {m_icf & m_ctl[4], m_ocf & m_ctl[3], m_tof & m_ctl[2]};
  endfunction

  // One clock of the reference model, applied from the inputs present before the edge.
  task automatic model_tick();
    bit s, cap, cmp, rt, rf, ri, wo, wfh, wfl;
    if (RST) begin
      m_frc = 16'h0000; m_ocr = 16'hFFFF; m_icr = 16'h0000;
      m_temp = 0; m_lsb = 0; m_ctl = 0;
      {m_icf, m_ocf, m_tof, a_icf, a_ocf, a_tof, m_inh, m_p21, m_prev} = '0;
      sq.delete();
      for (int i = 0; i < 2; i++) sq.push_back(1'b0);
      return;
    end
    s = sq[0];
    void'(sq.pop_front());
    sq.push_back(p20);
    if (!CE) return;
    cap = m_ctl[1] ? (s && !m_prev) : (!s && m_prev);
    m_prev = s;
    cmp = (m_frc == m_ocr) && !m_inh;
    rt  = bus.sel && bus.rd && bus.ra == 3'd0;
    rf  = bus.sel && bus.rd && bus.ra == 3'd1;
    ri  = bus.sel && bus.rd && bus.ra == 3'd5;
    wfh = bus.sel && bus.wr && bus.ra == 3'd1;
    wfl = bus.sel && bus.wr && bus.ra == 3'd2;
    wo  = bus.sel && bus.wr && (bus.ra == 3'd3 || bus.ra == 3'd4);
    if (rt) begin
      if (m_icf) a_icf = 1;
      if (m_ocf) a_ocf = 1;
      if (m_tof) a_tof = 1;
    end
    if (ri && a_icf) begin m_icf = 0; a_icf = 0; end
    if (wo && a_ocf) begin m_ocf = 0; a_ocf = 0; end
    if (rf && a_tof) begin m_tof = 0; a_tof = 0; end
    if (cap) begin m_icf = 1; m_icr = m_frc; end
    if (cmp) begin m_ocf = 1; m_p21 = m_ctl[0]; end
    if (!wfh && !wfl && m_frc == 16'hFFFF) m_tof = 1;
    if (rf) m_lsb = m_frc[7:0];
    if (bus.sel && bus.wr && bus.ra == 3'd0) m_ctl = bus.di[4:0];
    if (bus.sel && bus.wr && bus.ra == 3'd3) m_ocr[15:8] = bus.di;
    if (bus.sel && bus.wr && bus.ra == 3'd4) m_ocr[7:0]  = bus.di;
    m_inh = wo;
    if (wfh) begin m_temp = bus.di; m_frc = FRC_WR_PRESET_DEF; end
    else if (wfl) m_frc = {m_temp, bus.di};
    else m_frc = m_frc + 16'd1;
  endtask

  task automatic clk();
    model_tick();
    @(posedge CLKp);
    #1;
  endtask

  task automatic drive(input bit ce, sel, rd, wr, input logic [2:0] ra, input logic [7:0] di);
    CE = ce; bus.sel = sel; bus.rd = rd; bus.wr = wr; bus.ra = ra; bus.di = di;
    #1;
  endtask

  task automatic op(input bit ce, sel, rd, wr, input logic [2:0] ra, input logic [7:0] di);
    drive(ce, sel, rd, wr, ra, di);
    clk();
  endtask

  // side-effect-free register peek (CE=0)
  task automatic peek(input logic [2:0] ra, input logic [7:0] exp, input string name);
    drive(0, 1, 1, 0, ra, 8'h00);
    chk(name, {8'h00, bus.dout}, {8'h00, exp});
    clk();
  endtask

  task automatic add(input bit ce, sel, rd, wr, input logic [2:0] ra, input logic [7:0] di,
                     input logic [7:0] dout, input logic [2:0] irq);
    vec_t v;
    v.ce = ce; v.sel = sel; v.rd = rd; v.wr = wr; v.ra = ra; v.di = di;
    v.dout = dout; v.irq = irq;
    tv.push_back(v);
  endtask

  initial begin
    RST = 1; p20 = 0;
    drive(0, 0, 0, 0, 3'd0, 8'h00);
    clk(); clk();
    RST = 0;

    // reset state, count/overflow, TOF two-step clear, buffered 16-bit read, FRC write
    add(0,1,1,0,3'd0,8'h00,8'h00,3'b000); add(0,1,1,0,3'd1,8'h00,8'h00,3'b000);
    add(0,1,1,0,3'd3,8'h00,8'hFF,3'b000); add(0,1,1,0,3'd4,8'h00,8'hFF,3'b000);
    add(0,1,1,0,3'd5,8'h00,8'h00,3'b000); add(0,0,1,0,3'd3,8'h00,8'h00,3'b000);
    add(0,1,1,0,3'd7,8'h00,8'h00,3'b000); add(1,1,0,1,3'd0,8'h04,8'h00,3'b000);
    add(0,1,1,0,3'd0,8'h00,8'h04,3'b000); add(1,1,0,1,3'd1,8'hFF,8'h00,3'b000);
    add(1,1,0,1,3'd2,8'hFE,8'h00,3'b000); add(0,1,1,0,3'd1,8'h00,8'hFF,3'b000);
    add(1,0,0,0,3'd0,8'h00,8'h00,3'b000); add(1,1,1,0,3'd1,8'h00,8'hFF,3'b000);
    add(0,1,1,0,3'd2,8'h00,8'hFF,3'b001); add(0,1,1,0,3'd1,8'h00,8'h00,3'b001);
    add(0,1,1,0,3'd0,8'h00,8'h64,3'b001); add(1,1,1,0,3'd1,8'h00,8'h00,3'b001);
    add(0,1,1,0,3'd0,8'h00,8'h64,3'b001); add(1,1,1,0,3'd0,8'h00,8'h64,3'b001);
    add(1,1,1,0,3'd1,8'h00,8'h00,3'b001); add(0,1,1,0,3'd0,8'h00,8'h44,3'b000);
    add(1,1,0,1,3'd1,8'h12,8'h00,3'b000); add(1,1,0,1,3'd2,8'hFE,8'h02,3'b000);
    add(1,0,0,0,3'd0,8'h00,8'h00,3'b000); add(1,1,1,0,3'd1,8'h00,8'h12,3'b000);
    add(1,1,1,0,3'd2,8'h00,8'hFF,3'b000); add(0,1,1,0,3'd1,8'h00,8'h13,3'b000);
    add(1,1,0,1,3'd1,8'hAB,8'h13,3'b000); add(0,1,1,0,3'd1,8'h00,8'hFF,3'b000);
    add(1,1,1,0,3'd1,8'h00,8'hFF,3'b000); add(0,1,1,0,3'd2,8'h00,8'hF8,3'b000);
    add(1,1,0,1,3'd2,8'hCD,8'hF8,3'b000); add(0,1,1,0,3'd1,8'h00,8'hAB,3'b000);
    add(1,1,1,0,3'd1,8'h00,8'hAB,3'b000); add(0,1,1,0,3'd2,8'h00,8'hCD,3'b000);
    add(1,1,1,0,3'd1,8'h00,8'hAB,3'b000); add(0,1,1,0,3'd2,8'h00,8'hCE,3'b000);
    add(0,1,1,0,3'd0,8'h00,8'h44,3'b000);
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].ce, tv[i].sel, tv[i].rd, tv[i].wr, tv[i].ra, tv[i].di);
      chk($sformatf("vec%0d dout", i), {8'h00, bus.dout}, {8'h00, tv[i].dout});
      chk($sformatf("vec%0d irq", i), {13'h0, irq_ici, irq_oci, irq_toi}, {13'h0, tv[i].irq});
      clk();
    end

    // compare: armed OCF cleared by OCR write, then match at 0040 with OLVL=1
    op(1,1,0,1,3'd0,8'h0D);
    op(1,1,0,1,3'd3,8'h00);
    peek(3'd0, 8'h0D, "ocf armed clear");
    op(1,1,0,1,3'd4,8'h40);
    op(1,1,0,1,3'd1,8'h00);
    op(1,1,0,1,3'd2,8'h3C);
    for (int i = 0; i < 4; i++) op(1,0,0,0,3'd0,8'h00);
    chk("p21 before match", {15'h0, p21}, 16'h0);
    peek(3'd0, 8'h0D, "no ocf before match");
    op(1,0,0,0,3'd0,8'h00);
    chk("p21 after match", {15'h0, p21}, 16'h1);
    chk("irq_oci after match", {15'h0, irq_oci}, 16'h1);
    peek(3'd0, 8'h4D, "ocf on match");
    // compare inhibited in the CE cycle after an OCR write
    op(1,1,1,0,3'd0,8'h00);
    op(1,1,0,1,3'd3,8'h00);
    op(1,1,0,1,3'd4,8'h44);
    op(1,0,0,0,3'd0,8'h00);
    chk("irq_oci inhibited", {15'h0, irq_oci}, 16'h0);
    peek(3'd0, 8'h0D, "ocf inhibited");

    // capture: falling edge with IEDG=0, rising edge ignored
    op(1,1,0,1,3'd0,8'h10);
    p20 = 1;
    for (int i = 0; i < 4; i++) op(1,0,0,0,3'd0,8'h00);
    peek(3'd0, 8'h10, "rising ignored");
    peek(3'd5, 8'h00, "icrh no capture");
    op(1,1,0,1,3'd1,8'h20);
    p20 = 0;
    op(1,1,0,1,3'd2,8'h00);
    op(1,0,0,0,3'd0,8'h00);
    op(1,0,0,0,3'd0,8'h00);
    chk("irq_ici on capture", {15'h0, irq_ici}, 16'h1);
    peek(3'd0, 8'h90, "icf on capture");
    peek(3'd5, 8'h20, "icrh capture");
    peek(3'd6, 8'h01, "icrl capture");
    // capture coinciding with an armed ICRH read
    p20 = 1;
    for (int i = 0; i < 3; i++) op(1,0,0,0,3'd0,8'h00);
    op(1,1,1,0,3'd0,8'h00);
    p20 = 0;
    op(1,0,0,0,3'd0,8'h00);
    op(1,0,0,0,3'd0,8'h00);
    op(1,1,1,0,3'd5,8'h00);
    peek(3'd0, 8'h90, "set beats clear");
    op(1,1,1,0,3'd5,8'h00);
    peek(3'd0, 8'h90, "disarmed after set");
    op(1,1,1,0,3'd0,8'h00);
    op(1,1,1,0,3'd5,8'h00);
    peek(3'd0, 8'h10, "icf cleared");
    chk("irq_ici cleared", {15'h0, irq_ici}, 16'h0);

    // reset during an active write
    RST = 1;
    op(1,1,0,1,3'd1,8'h55);
    RST = 0;
    chk("p21 after reset", {15'h0, p21}, 16'h0);
    peek(3'd0, 8'h00, "rst tcsr");
    peek(3'd1, 8'h00, "rst frch");
    peek(3'd2, 8'h00, "rst lsb");
    peek(3'd4, 8'hFF, "rst ocrl");
    op(1,1,1,0,3'd1,8'h00);
    peek(3'd2, 8'h00, "count from zero");

    // randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      int k;
      logic [7:0] d;
      logic [2:0] a;
      RST = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 5) == 0) p20 = ~p20;
      k = $urandom_range(0, 2);
      a = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      if (k == 2 && a == 3'd3 && $urandom_range(0, 3) != 0) d = m_frc[15:8];
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, k == 1, k == 2, a, d);
      chk($sformatf("rnd%0d dout", c), {8'h00, bus.dout}, {8'h00, m_read(bus.sel, bus.ra)});
      chk($sformatf("rnd%0d irq", c), {13'h0, irq_ici, irq_oci, irq_toi}, {13'h0, m_irq()});
      chk($sformatf("rnd%0d p21", c), {15'h0, p21}, {15'h0, m_p21});
      clk();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
